cpu6_mux_port: RTL

//  Memory-mapped serial port (MUX channel 0) on the CPU6 external bus, downstream of the CPU.

---
 rtl/cpu6_mux_port_if.sv | 21 ++
 rtl/cpu6_mux_port.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu6_mux_port_if.sv
// CPU6 external-bus view of a memory-mapped peripheral: address/data/strobes in, decode and read data out.
// Latency: none of its own; it only bundles wires.
// Backpressure: none; the CPU bus never stalls, so the peripheral must absorb or drop each access.
interface cpu6_mux_port_if;
  logic [15:0] address;
  logic [7:0]  write_data;
  logic        write_en;
  logic        read_strobe;
  logic        sel;
  logic [7:0]  read_data;

  modport master (
    output address, write_data, write_en, read_strobe,
    input  sel, read_data
  );

  modport slave (
    input  address, write_data, write_en, read_strobe,
    output sel, read_data
  );
endinterface

// File: rtl/cpu6_mux_port.sv
// MUX channel 0 serial port: status/data registers on the CPU6 bus, TX FIFO + 8N1 serialiser, 8N1 RX holding register.
// Latency: write edge N, FIFO pop at N+1, start bit on tx_out from N+2; RX byte delivered mid stop bit.
// Backpressure: none on the bus; a data write to a full FIFO is dropped and flagged in tx_drop.
module cpu6_mux_port #(
  parameter logic [15:0] BASE_ADDR    = 16'hF200,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          TX_DEPTH     = 4
) (
  input  logic            clock,
  input  logic            reset,
  cpu6_mux_port_if.slave  bus,
  input  logic            rx_in,
  output logic            tx_out,
  output logic            irq
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(TX_DEPTH);

  // Address decode and bus strobes
  logic is_stat, is_data, push_req, stat_wr, rd_clr;
  assign is_stat  = (bus.address == BASE_ADDR);
  assign is_data  = (bus.address == BASE_ADDR + 16'd1);
  assign push_req = bus.write_en & is_data;
  assign stat_wr  = bus.write_en & is_stat;
  assign rd_clr   = bus.read_strobe & is_data;
  assign bus.sel  = is_stat | is_data;

  // TX FIFO bookkeeping
  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic          fifo_full, fifo_empty, push, pop;
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = push_req & ~fifo_full;

  // TX serialiser state
  logic [1:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_bit_end, tx_idle;
  assign tx_bit_end = (tx_cnt == BIT_LAST);
  // Pop either from idle or straight out of a finishing stop bit so queued frames abut.
  assign pop     = ~fifo_empty & ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_bit_end));
  assign tx_idle = fifo_empty & (tx_state == S_IDLE);

  // FIFO storage; contents need no reset since the count gates every read
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= bus.write_data;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // TX frame sequencing: start, eight data bits LSB first, stop
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          tx_cnt <= '0;
          if (pop) begin
            tx_state <= S_START;
            tx_shift <= fifo_mem[rd_ptr];
          end
        end
        S_START: begin
          tx_cnt <= tx_bit_end ? '0 : tx_cnt + CW'(1);
          if (tx_bit_end) begin
            tx_state <= S_DATA;
            tx_bit   <= '0;
          end
        end
        S_DATA: begin
          tx_cnt <= tx_bit_end ? '0 : tx_cnt + CW'(1);
          if (tx_bit_end) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_state <= S_STOP;
          end
        end
        default: begin
          tx_cnt <= tx_bit_end ? '0 : tx_cnt + CW'(1);
          if (tx_bit_end) begin
            if (pop) begin
              tx_state <= S_START;
              tx_shift <= fifo_mem[rd_ptr];
            end else begin
              tx_state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Line driver registered one cycle behind the state, so the start bit appears the edge after the pop
  always_ff @(posedge clock) begin
    if (!reset) tx_out <= 1'b1;
    else begin
      case (tx_state)
        S_START: tx_out <= 1'b0;
        S_DATA:  tx_out <= tx_shift[0];
        default: tx_out <= 1'b1;
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous serial input
  logic rx_meta, rx_sync;
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
    end
  end

  // RX deserialiser state
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_bit_end, rx_deliver;
  assign rx_bit_end = (rx_cnt == BIT_LAST);
  assign rx_deliver = (rx_state == S_STOP) & rx_bit_end;

  // RX frame sequencing: half-bit start check rejects glitches, then whole-bit steps to each bit centre
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          rx_cnt <= '0;
          if (!rx_sync) rx_state <= S_START;
        end
        S_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          rx_cnt <= rx_bit_end ? '0 : rx_cnt + CW'(1);
          if (rx_bit_end) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
          end
        end
        default: begin
          rx_cnt <= rx_bit_end ? '0 : rx_cnt + CW'(1);
          if (rx_bit_end) rx_state <= S_IDLE;
        end
      endcase
    end
  end

  // Status flags, holding register and interrupt; a delivery outranks a same-cycle data read
  logic       rx_ready, overrun, framing, tx_drop, rx_ie;
  logic [7:0] rx_hold;
  logic       rx_ready_nxt, rx_ie_nxt;
  assign rx_ready_nxt = rx_deliver | (rx_ready & ~rd_clr);
  assign rx_ie_nxt    = stat_wr ? bus.write_data[0] : rx_ie;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_ready <= 1'b0;
      overrun  <= 1'b0;
      framing  <= 1'b0;
      tx_drop  <= 1'b0;
      rx_ie    <= 1'b0;
      irq      <= 1'b0;
      rx_hold  <= '0;
    end else begin
      rx_ready <= rx_ready_nxt;
      rx_ie    <= rx_ie_nxt;
      irq      <= rx_ready_nxt & rx_ie_nxt;
      if (rx_deliver) begin
        rx_hold <= rx_shift;
        overrun <= (overrun | rx_ready) & ~rd_clr;
        framing <= ~rx_sync | (framing & ~rd_clr);
      end else if (rd_clr) begin
        overrun <= 1'b0;
        framing <= 1'b0;
      end
      if (push_req & fifo_full)           tx_drop <= 1'b1;
      else if (stat_wr & bus.write_data[4]) tx_drop <= 1'b0;
    end
  end

  // Read mux; status reads are side-effect free
  always_comb begin
    bus.read_data = 8'h00;
    if (is_stat)
      bus.read_data = {tx_idle, 2'b00, tx_drop, framing, overrun, ~fifo_full, rx_ready};
    else if (is_data)
      bus.read_data = rx_hold;
  end
endmodule
